// File: rtl/vector_line_engine.sv
// Display-list sequencer for an XY vector display: fetches command words and drives X/Y DAC
// codes plus a blank strobe, executing blanked MOVEs and beam-on Bresenham DRAW lines.
module vector_line_engine #(
  parameter int unsigned DAC_WIDTH    = 8,
  parameter int unsigned ADDRESSWIDTH = 16,
  parameter int unsigned DATAWIDTH    = 2 * DAC_WIDTH + 2,
  parameter int unsigned STEP_DIV     = 4,
  parameter int unsigned SETTLE       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  output logic [ADDRESSWIDTH-1:0] mem_addr,
  output logic                    mem_rd,
  input  logic [DATAWIDTH-1:0]    mem_data,
  output logic [DAC_WIDTH-1:0]    x_dac,
  output logic [DAC_WIDTH-1:0]    y_dac,
  output logic                    blank,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int unsigned EW   = DAC_WIDTH + 2;
  localparam int unsigned DivW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned SetW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] CmdMove = 2'b00;
  localparam logic [1:0] CmdDraw = 2'b01;
  localparam logic [1:0] CmdEnd  = 2'b10;

  if (DATAWIDTH != 2 * DAC_WIDTH + 2) begin : g_width_check
    $error("vector_line_engine: DATAWIDTH must equal 2*DAC_WIDTH+2");
  end

  typedef enum logic [2:0] {
    StIdle, StFetch, StWait, StDecode, StSettle, StSetup, StStep, StEnd
  } state_e;

  state_e                state;
  logic [1:0]            cmd;
  logic [DAC_WIDTH-1:0]  tx, ty, cx, cy, dx, dy, adx, ady;
  logic                  sx_neg, sy_neg;
  logic signed [EW-1:0]  err;
  logic signed [EW:0]    e2, dx_w, dy_w, err_w;
  logic                  step_x, step_y;
  logic [DivW-1:0]       div;
  logic [SetW-1:0]       settle_cnt;

  assign busy = (state != StIdle);

  assign adx  = (tx >= x_dac) ? tx - x_dac : x_dac - tx;
  assign ady  = (ty >= y_dac) ? ty - y_dac : y_dac - ty;

  // Error term is widened by one bit so 2*err never overflows.
  assign dx_w   = $signed({3'b000, dx});
  assign dy_w   = $signed({3'b000, dy});
  assign e2     = $signed({err, 1'b0});
  assign step_x = (e2 > -dy_w);
  assign step_y = (e2 < dx_w);

  always_comb begin
    err_w = {err[EW-1], err};
    if (step_x) err_w = err_w - dy_w;
    if (step_y) err_w = err_w + dx_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      x_dac      <= '0;
      y_dac      <= '0;
      blank      <= 1'b1;
      frame_done <= 1'b0;
      cmd        <= '0;
      tx         <= '0;
      ty         <= '0;
      cx         <= '0;
      cy         <= '0;
      dx         <= '0;
      dy         <= '0;
      sx_neg     <= 1'b0;
      sy_neg     <= 1'b0;
      err        <= '0;
      div        <= '0;
      settle_cnt <= '0;
    end else begin
      mem_rd     <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (enable) begin
            state  <= StFetch;
            mem_rd <= 1'b1;
          end
        end
        StFetch: state <= StWait;
        StWait: begin
          cmd        <= mem_data[DATAWIDTH-1 -: 2];
          tx         <= mem_data[2*DAC_WIDTH-1 -: DAC_WIDTH];
          ty         <= mem_data[DAC_WIDTH-1:0];
          mem_addr   <= mem_addr + 1'b1;
          frame_done <= &mem_addr;
          state      <= StDecode;
          // A MOVE target must be on the DACs in the decode clock itself.
          if (mem_data[DATAWIDTH-1 -: 2] == CmdMove) begin
            x_dac <= mem_data[2*DAC_WIDTH-1 -: DAC_WIDTH];
            y_dac <= mem_data[DAC_WIDTH-1:0];
            blank <= 1'b1;
          end
        end
        StDecode: begin
          unique case (cmd)
            CmdMove: begin
              settle_cnt <= '0;
              state      <= StSettle;
            end
            CmdDraw: state <= StSetup;
            CmdEnd: begin
              state      <= StEnd;
              blank      <= 1'b1;
              frame_done <= 1'b1;
              mem_addr   <= '0;
            end
            default: begin
              if (enable) begin
                state  <= StFetch;
                mem_rd <= 1'b1;
              end else begin
                state <= StIdle;
                blank <= 1'b1;
              end
            end
          endcase
        end
        StSettle: begin
          if (settle_cnt == SetW'(SETTLE - 1)) begin
            if (enable) begin
              state  <= StFetch;
              mem_rd <= 1'b1;
            end else begin
              state <= StIdle;
              blank <= 1'b1;
            end
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        StSetup: begin
          dx     <= adx;
          dy     <= ady;
          sx_neg <= (tx < x_dac);
          sy_neg <= (ty < y_dac);
          err    <= $signed({2'b00, adx}) - $signed({2'b00, ady});
          cx     <= x_dac;
          cy     <= y_dac;
          div    <= '0;
          state  <= StStep;
        end
        StStep: begin
          if (div == DivW'(STEP_DIV - 1)) begin
            div   <= '0;
            x_dac <= cx;
            y_dac <= cy;
            blank <= 1'b0;
            if (cx == tx && cy == ty) begin
              if (enable) begin
                state  <= StFetch;
                mem_rd <= 1'b1;
              end else begin
                state <= StIdle;
                blank <= 1'b1;
              end
            end else begin
              err <= err_w[EW-1:0];
              if (step_x) cx <= sx_neg ? cx - 1'b1 : cx + 1'b1;
              if (step_y) cy <= sy_neg ? cy - 1'b1 : cy + 1'b1;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        StEnd: begin
          if (enable) begin
            state  <= StFetch;
            mem_rd <= 1'b1;
          end else begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_line_engine.sv
// Bench for vector_line_engine: directed and random display lists compared against a
// point-trace reference model, plus enable-drop, address-wrap and async-reset checks.
module tb_vector_line_engine;

  localparam int DW   = 8;
  localparam int AW   = 16;
  localparam int DATW = 18;
  localparam int SD   = 4;
  localparam int ST   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, enable;
  logic [AW-1:0]   mem_addr;
  logic            mem_rd;
  logic [DATW-1:0] mem_data;
  logic [DW-1:0]   x_dac, y_dac;
  logic            blank, busy, frame_done;
  logic [DATW-1:0] mem [0:255];

  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr[7:0]];

  vector_line_engine #(
    .DAC_WIDTH(DW), .ADDRESSWIDTH(AW), .DATAWIDTH(DATW), .STEP_DIV(SD), .SETTLE(ST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_data(mem_data), .x_dac(x_dac), .y_dac(y_dac), .blank(blank), .busy(busy),
    .frame_done(frame_done)
  );

  logic            rst_n_w, enable_w;
  logic [2:0]      mem_addr_w;
  logic            mem_rd_w;
  logic [DATW-1:0] mem_data_w;
  logic [DW-1:0]   x_w, y_w;
  logic            blank_w, busy_w, frame_done_w;

  assign mem_data_w = 18'h30000;  // every word is a NOP

  vector_line_engine #(
    .DAC_WIDTH(DW), .ADDRESSWIDTH(3), .DATAWIDTH(DATW), .STEP_DIV(SD), .SETTLE(ST)
  ) dut_w (
    .clk(clk), .rst_n(rst_n_w), .enable(enable_w), .mem_addr(mem_addr_w), .mem_rd(mem_rd_w),
    .mem_data(mem_data_w), .x_dac(x_w), .y_dac(y_w), .blank(blank_w), .busy(busy_w),
    .frame_done(frame_done_w)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observed trace: every change of {blank, x, y}, with the cycle it appeared in.
  logic [16:0] obs [$];
  int          obs_t [$];
  logic [16:0] prev;
  int          cyc = 0;
  int          fd_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if ({blank, x_dac, y_dac} != prev) begin
        prev = {blank, x_dac, y_dac};
        obs.push_back(prev);
        obs_t.push_back(cyc);
      end
      if (frame_done) fd_cnt++;
    end
  end

  // Expected trace; exp_s marks points that must follow the previous one by one step period.
  logic [16:0] exp_q [$];
  bit          exp_s [$];
  logic [16:0] last;

  function automatic logic [17:0] word(input int c, input int x, input int y);
    return {2'(c), 8'(x), 8'(y)};
  endfunction

  task automatic build_model(input int n);
    int x, y, tx, ty, dx, dy, sx, sy, err, e2, k;
    bit p0, done;
    logic [17:0] w;
    logic [16:0] t;
    x = 0; y = 0; done = 0;
    last = {1'b1, 16'd0};
    exp_q.delete();
    exp_s.delete();
    for (int i = 0; i < n && !done; i++) begin
      w  = mem[i];
      tx = int'(w[15:8]);
      ty = int'(w[7:0]);
      case (w[17:16])
        2'b00: begin
          t = {1'b1, 8'(tx), 8'(ty)};
          if (t != last) begin exp_q.push_back(t); exp_s.push_back(1'b0); last = t; end
          x = tx; y = ty;
        end
        2'b01: begin
          dx = (tx > x) ? tx - x : x - tx;
          dy = (ty > y) ? ty - y : y - ty;
          sx = (x < tx) ? 1 : -1;
          sy = (y < ty) ? 1 : -1;
          err = dx - dy;
          k = 0; p0 = 0;
          forever begin
            t = {1'b0, 8'(x), 8'(y)};
            if (t != last) begin
              exp_q.push_back(t);
              exp_s.push_back((k >= 2) || (k == 1 && p0));
              last = t;
              if (k == 0) p0 = 1;
            end
            if (x == tx && y == ty) break;
            e2 = 2 * err;
            if (e2 > -dy) begin err -= dy; x += sx; end
            if (e2 < dx) begin err += dx; y += sy; end
            k++;
          end
        end
        2'b10: begin
          t = {1'b1, 8'(x), 8'(y)};
          if (t != last) begin exp_q.push_back(t); exp_s.push_back(1'b0); last = t; end
          done = 1;
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_trace(input string name);
    int n;
    check($sformatf("%s trace length", name), obs.size(), exp_q.size());
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s point %0d", name, i), obs[i], exp_q[i]);
      if (exp_s[i] && i > 0)
        check($sformatf("%s step period %0d", name, i), obs_t[i] - obs_t[i-1], SD);
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    obs.delete();
    obs_t.delete();
    prev   = {1'b1, 16'd0};
    fd_cnt = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_frame_done(input string name, input int limit);
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (frame_done) break;
    end
    check({name, " frame_done seen"}, frame_done, 1'b1);
  endtask

  task automatic wait_idle(input string name, input int limit);
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check({name, " busy low"}, busy, 1'b0);
  endtask

  task automatic run_frame(input string name);
    enable = 1'b1;
    wait_frame_done(name, 20000);
    enable = 1'b0;
    wait_idle(name, 100);
    repeat (2) @(negedge clk);
  endtask

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  function automatic int pick_coord();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return 255;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, cx, cy, r, rd;
    rst_n_w  = 1'b0;
    enable_w = 1'b0;
    mem_data = '0;

    // Reset state and idle hold with enable low.
    do_reset();
    @(negedge clk);
    check("reset mem_addr", mem_addr, 0);
    check("reset mem_rd", mem_rd, 0);
    check("reset xy", {x_dac, y_dac}, 0);
    check("reset blank", blank, 1);
    check("reset busy", busy, 0);
    check("reset frame_done", frame_done, 0);
    repeat (5) @(negedge clk);
    check("idle stays idle", {busy, mem_rd}, 0);

    // MOVE(10,10), DRAW(14,10), END.
    mem[0] = word(0, 10, 10);
    mem[1] = word(1, 14, 10);
    mem[2] = word(2, 0, 0);
    build_model(3);
    do_reset();
    run_frame("A");
    compare_trace("A");
    check("A frame_done pulses", fd_cnt, 1);
    check("A mem_addr after end", mem_addr, 0);
    check("A move dwell", (obs.size() > 1) && (obs_t[1] - obs_t[0] > ST), 1);

    // Diagonal, negative-direction at the edge, and zero-length lines.
    mem[0] = word(0, 0, 0);
    mem[1] = word(1, 3, 6);
    mem[2] = word(0, 255, 255);
    mem[3] = word(1, 250, 255);
    mem[4] = word(0, 5, 5);
    mem[5] = word(1, 5, 5);
    mem[6] = word(3, 0, 0);
    mem[7] = word(2, 0, 0);
    build_model(8);
    do_reset();
    run_frame("B");
    compare_trace("B");

    // Random display lists.
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(3, 7);
      cx = 0; cy = 0;
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 9);
        if (r < 3) begin
          cx = pick_coord(); cy = pick_coord();
          mem[i] = word(0, cx, cy);
        end else if (r < 8) begin
          cx = clamp(cx + int'($urandom_range(0, 48)) - 24);
          cy = clamp(cy + int'($urandom_range(0, 48)) - 24);
          mem[i] = word(1, cx, cy);
        end else begin
          mem[i] = word(3, $urandom_range(0, 255), $urandom_range(0, 255));
        end
      end
      mem[n] = word(2, 0, 0);
      build_model(n + 1);
      do_reset();
      run_frame($sformatf("R%0d", f));
      compare_trace($sformatf("R%0d", f));
    end

    // Enable dropped during a 100-step line.
    mem[0] = word(0, 0, 0);
    mem[1] = word(1, 100, 0);
    mem[2] = word(0, 7, 7);
    mem[3] = word(2, 0, 0);
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!blank) break;
    end
    check("C line started", blank, 0);
    enable = 1'b0;
    wait_idle("C", 2000);
    check("C line completed", {x_dac, y_dac}, {8'd100, 8'd0});
    check("C blank in idle", blank, 1);
    check("C mem_addr held", mem_addr, 2);
    repeat (5) @(negedge clk);
    check("C no fetch while disabled", {busy, mem_rd}, 0);
    enable = 1'b1;
    wait_frame_done("C resume", 500);
    check("C resumed at next command", {x_dac, y_dac}, {8'd7, 8'd7});
    enable = 1'b0;
    wait_idle("C end", 100);

    // Reset asserted in the middle of a line.
    mem[0] = word(0, 10, 10);
    mem[1] = word(1, 60, 40);
    mem[2] = word(2, 0, 0);
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!blank) break;
    end
    repeat (6) @(negedge clk);
    check("D mid-line before reset", blank, 0);
    #2 rst_n = 1'b0;
    #1;
    check("D async reset xy", {x_dac, y_dac}, 0);
    check("D async reset ctl", {blank, busy, mem_rd, frame_done}, 4'b1000);
    check("D async reset addr", mem_addr, 0);
    enable = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Narrow address bus: eight NOPs wrap 7 -> 0 and pulse frame_done on the wrap.
    @(posedge clk);
    #1 rst_n_w = 1'b1;
    enable_w = 1'b1;
    for (int w = 0; w < 2; w++) begin
      rd = 0;
      for (int k = 0; k < 500; k++) begin
        @(negedge clk);
        if (mem_rd_w) rd++;
        if (frame_done_w) break;
      end
      check($sformatf("W%0d frame_done on wrap", w), frame_done_w, 1);
      check($sformatf("W%0d mem_addr wrapped", w), mem_addr_w, 0);
      check($sformatf("W%0d fetches per wrap", w), rd, 8);
    end
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (mem_rd_w && mem_addr_w != 0) break;
    end
    check("W mid-fetch reached", mem_rd_w, 1);
    #1 rst_n_w = 1'b0;
    #1;
    check("W async reset ctl", {mem_rd_w, busy_w, blank_w, frame_done_w}, 4'b0010);
    check("W async reset addr", mem_addr_w, 0);
    check("W async reset xy", {x_w, y_w}, 0);
    enable_w = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vector_line_engine.md
Name: vector_line_engine

Overview:
- Frame-list sequencer for the XY vector display.
- Fetches command words from a synchronous display-list ROM/RAM and executes MOVE (blanked jump) and DRAW (beam-on Bresenham line) commands.
- Drives X/Y DAC codes plus a blank strobe.
- Generalises the fixed 8-bit, 255x255 vector constants to a parametrised DAC width, step rate and settle time; sits between the display-list memory and the DAC pin-mapping output stage.

Parameters:
- DAC_WIDTH, 8: bits per axis; coordinate range 0..2^DAC_WIDTH-1.
- ADDRESSWIDTH, 16: display-list address width.
- DATAWIDTH, 2*DAC_WIDTH+2: command word width (18 at default). Any other value is a static elaboration error.
- STEP_DIV, 4: clocks per line step (>=1).
- SETTLE, 16: blanked dwell clocks after a MOVE (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run frames while high
- mem_addr  out  ADDRESSWIDTH  display-list read address
- mem_rd  out  1  read strobe; data valid exactly 1 clock later
- mem_data  in  DATAWIDTH  command word: [DW-1:DW-2]=cmd, next DAC_WIDTH bits = X, low DAC_WIDTH bits = Y
- x_dac  out  DAC_WIDTH  X coordinate
- y_dac  out  DAC_WIDTH  Y coordinate
- blank  out  1  1 = beam off
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-clock pulse at frame end

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE, mem_addr=0, mem_rd=0, x_dac=0, y_dac=0, blank=1, busy=0, frame_done=0.
- Command codes:
  - 00 MOVE
  - 01 DRAW
  - 10 END
  - 11 NOP (skip, no output change)
- IDLE -> FETCH when enable=1.
- FETCH:
  - mem_rd=1 for one clock at mem_addr.
  - WAIT: one clock.
  - DECODE: latches mem_data and increments mem_addr by 1, wrapping 2^ADDRESSWIDTH-1 -> 0.
- MOVE:
  - Same clock as DECODE: blank=1, x_dac/y_dac = target.
  - Hold SETTLE clocks, then FETCH. blank stays 1 into the next fetch.
- DRAW:
  - Setup clock: dx=|x1-x|, dy=|y1-y|, sx/sy = +1/-1, err = dx-dy (signed, DAC_WIDTH+2 bits).
  - blank=0 from the first step tick.
  - A step tick occurs every STEP_DIV clocks. On each tick, the current point is output, then:
    - if e2=2*err > -dy: err-=dy and x+=sx
    - if e2 < dx: err+=dx and y+=sy
  - Line ends after the tick that outputs the target point (endpoint inclusive).
  - Zero-length DRAW (target == current) outputs one point for one tick.
  - Next state is FETCH; blank stays 0 until a MOVE or END.
- END:
  - blank=1, frame_done=1 for one clock, mem_addr=0.
  - FETCH if enable=1, else IDLE.
- Address wrap without END (mem_addr wraps to 0 in DECODE) also pulses frame_done, in the same clock as the wrap.
- enable deasserted mid-command: the current command completes. At the next FETCH decision the engine goes to IDLE with blank=1, mem_addr held (resumes from there).
- Coordinates never leave the 0..2^DAC_WIDTH-1 range. Steps only move toward the target, so there is no overflow.
- No arithmetic saturation needed; all counters are sized to their parameters.
- Reset mid-line returns the engine to the reset state immediately. No partial output is held.

Test Plan:
- Reset then enable with list [MOVE(10,10), DRAW(14,10), END]:
  - x_dac=10, blank=1 for 16 clocks.
  - Then x steps 10,11,12,13,14 every 4 clocks with blank=0.
  - Then frame_done pulses once, mem_addr=0.
- Diagonal DRAW from (0,0) to (3,6):
  - Exactly 7 points output.
  - y increments every tick, x increments 3 times.
  - Final point (3,6).
- Negative direction DRAW from (255,255) to (250,255): x sequence 255..250, y constant, no wrap to 0.
- Zero-length DRAW at (5,5): exactly one tick with blank=0 at (5,5), then FETCH.
- Drop enable during a DRAW of 100 steps:
  - Line completes.
  - Engine enters IDLE, busy=0, blank=1.
  - Re-enable fetches from the next address.
- ADDRESSWIDTH=3, list of 8 NOPs:
  - mem_addr wraps 7->0.
  - frame_done pulses on the wrap.
  - Assert rst_n=0 mid-fetch: all outputs return to reset values asynchronously.
